mc_ctrl_fsm: RTL and testbench

MC_CTRL_FSM -- requirements
Module: mc_ctrl_fsm

---
 rtl/mc_pkg.sv | 52 +++++
 rtl/mc_op_decode.sv | 23 ++
 rtl/mc_ctrl_fsm.sv | 167 ++++++++++++++++
 tb/tb_mc_ctrl_fsm.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mc_pkg.sv
// Shared encodings for the multicycle controller: state codes, opcodes, mux/ALU selects.
package mc_pkg;

    localparam logic [3:0] StFetch  = 4'd0;
    localparam logic [3:0] StDecode = 4'd1;
    localparam logic [3:0] StMemAdr = 4'd2;
    localparam logic [3:0] StMemRd  = 4'd3;
    localparam logic [3:0] StMemWb  = 4'd4;
    localparam logic [3:0] StMemWr  = 4'd5;
    localparam logic [3:0] StExec   = 4'd6;
    localparam logic [3:0] StRwb    = 4'd7;
    localparam logic [3:0] StBeq    = 4'd8;
    localparam logic [3:0] StIExec  = 4'd9;
    localparam logic [3:0] StIwb    = 4'd10;
    localparam logic [3:0] StJump   = 4'd11;
    localparam logic [3:0] StHalt   = 4'd12;
    localparam logic [3:0] StIll    = 4'd13;

    localparam logic [3:0] OpAlu0  = 4'b0000;
    localparam logic [3:0] OpImm   = 4'b0001;
    localparam logic [3:0] OpAlu1  = 4'b0010;
    localparam logic [3:0] OpStore = 4'b1001;
    localparam logic [3:0] OpLoad  = 4'b1010;
    localparam logic [3:0] OpBeq   = 4'b1011;
    localparam logic [3:0] OpJump  = 4'b1100;
    localparam logic [3:0] OpHalt  = 4'b1111;

    localparam logic [1:0] SrcBReg = 2'b00;
    localparam logic [1:0] SrcBOne = 2'b01;
    localparam logic [1:0] SrcBImm = 2'b10;
    localparam logic [1:0] SrcBBr  = 2'b11;

    localparam logic [1:0] PcSrcAlu    = 2'b00;
    localparam logic [1:0] PcSrcAluOut = 2'b01;
    localparam logic [1:0] PcSrcJump   = 2'b10;

    localparam logic [1:0] AluAdd   = 2'b00;
    localparam logic [1:0] AluSub   = 2'b01;
    localparam logic [1:0] AluFunct = 2'b10;

    typedef enum logic [2:0] {
        ClsLoad,
        ClsStore,
        ClsAlu,
        ClsImm,
        ClsBeq,
        ClsJump,
        ClsHalt,
        ClsIll
    } op_class_e;

endpackage

// File: rtl/mc_op_decode.sv
// Combinational mapping of the 4-bit major opcode to an instruction class.
module mc_op_decode
    import mc_pkg::*;
(
    input  logic [3:0] op_i,
    output op_class_e  cls_o
);

    always_comb begin
        cls_o = ClsIll;
        case (op_i)
            OpLoad:         cls_o = ClsLoad;
            OpStore:        cls_o = ClsStore;
            OpAlu0, OpAlu1: cls_o = ClsAlu;
            OpImm:          cls_o = ClsImm;
            OpBeq:          cls_o = ClsBeq;
            OpJump:         cls_o = ClsJump;
            OpHalt:         cls_o = ClsHalt;
            default:        cls_o = ClsIll;
        endcase
    end

endmodule

// File: rtl/mc_ctrl_fsm.sv
// Multicycle CPU control FSM: sequences fetch/decode/execute and drives datapath controls.
module mc_ctrl_fsm
    import mc_pkg::*;
#(
    parameter int unsigned OP_W    = 4,
    parameter int unsigned WAIT_EN = 1,
    parameter int unsigned RET_W   = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [OP_W-1:0]  op,
    input  logic             zero,
    input  logic             mem_ready,
    input  logic             resume,
    output logic             iord,
    output logic             mem_read,
    output logic             mem_write,
    output logic             mem_to_reg,
    output logic             ir_write,
    output logic             reg_dst,
    output logic             reg_write,
    output logic             alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [1:0]       pc_source,
    output logic [1:0]       alu_op,
    output logic             pc_sel,
    output logic             illegal,
    output logic             halted,
    output logic [RET_W-1:0] retire_cnt,
    output logic [3:0]       state_o
);

    logic [3:0]       state_q, state_d;
    logic [RET_W-1:0] retire_q;
    logic             retire_inc;
    logic             mem_done;
    logic             pc_write, pc_write_cond;
    op_class_e        op_cls;

    mc_op_decode u_op_decode (
        .op_i  (op[OP_W-1 -: 4]),
        .cls_o (op_cls)
    );

    // With waits disabled every memory access is treated as completing immediately.
    assign mem_done = (WAIT_EN == 0) || mem_ready;

    always_comb begin
        state_d = state_q;
        case (state_q)
            StFetch:  if (mem_done) state_d = StDecode;
            StDecode: begin
                case (op_cls)
                    ClsLoad, ClsStore: state_d = StMemAdr;
                    ClsAlu:            state_d = StExec;
                    ClsImm:            state_d = StIExec;
                    ClsBeq:            state_d = StBeq;
                    ClsJump:           state_d = StJump;
                    ClsHalt:           state_d = StHalt;
                    default:           state_d = StIll;
                endcase
            end
            StMemAdr: state_d = (op_cls == ClsStore) ? StMemWr : StMemRd;
            StMemRd:  if (mem_done) state_d = StMemWb;
            StMemWr:  if (mem_done) state_d = StFetch;
            StExec:   state_d = StRwb;
            StIExec:  state_d = StIwb;
            StHalt:   if (resume) state_d = StFetch;
            default:  state_d = StFetch;
        endcase
    end

    always_comb begin
        retire_inc = 1'b0;
        case (state_q)
            StMemWb, StRwb, StIwb, StBeq, StJump: retire_inc = 1'b1;
            StMemWr:  retire_inc = mem_done;
            StDecode: retire_inc = (op_cls == ClsHalt);
            default:  retire_inc = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= StFetch;
            retire_q <= '0;
        end else begin
            state_q <= state_d;
            if (retire_inc) retire_q <= retire_q + RET_W'(1);
        end
    end

    always_comb begin
        iord          = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        mem_to_reg    = 1'b0;
        ir_write      = 1'b0;
        reg_dst       = 1'b0;
        reg_write     = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = SrcBReg;
        pc_source     = PcSrcAlu;
        alu_op        = AluAdd;
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        illegal       = 1'b0;
        halted        = 1'b0;
        case (state_q)
            StFetch: begin
                mem_read  = 1'b1;
                alu_src_b = SrcBOne;
                // IR and PC only latch once the fetch has actually completed.
                ir_write  = mem_done;
                pc_write  = mem_done;
            end
            StDecode: alu_src_b = SrcBBr;
            StMemAdr: begin
                alu_src_a = 1'b1;
                alu_src_b = SrcBImm;
            end
            StMemRd: begin
                mem_read = 1'b1;
                iord     = 1'b1;
            end
            StMemWb: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
            end
            StMemWr: begin
                mem_write = 1'b1;
                iord      = 1'b1;
            end
            StExec: begin
                alu_src_a = 1'b1;
                alu_op    = AluFunct;
            end
            StRwb: begin
                reg_dst   = 1'b1;
                reg_write = 1'b1;
            end
            StIExec: begin
                alu_src_a = 1'b1;
                alu_src_b = SrcBImm;
            end
            StIwb:   reg_write = 1'b1;
            StBeq: begin
                alu_src_a     = 1'b1;
                alu_op        = AluSub;
                pc_write_cond = 1'b1;
                pc_source     = PcSrcAluOut;
            end
            StJump: begin
                pc_write  = 1'b1;
                pc_source = PcSrcJump;
            end
            StHalt:  halted  = 1'b1;
            StIll:   illegal = 1'b1;
            default: ;
        endcase
    end

    assign pc_sel     = pc_write | (pc_write_cond & zero);
    assign retire_cnt = retire_q;
    assign state_o    = state_q;

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Directed-vector bench for mc_ctrl_fsm: default instance plus a RET_W=4, WAIT_EN=0 instance.
module tb_mc_ctrl_fsm;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset = 1'b1;
    logic [3:0]  op = 4'b0000;
    logic        zero = 1'b0;
    logic        mem_ready = 1'b1;
    logic        resume = 1'b0;
    logic        iord, mem_read, mem_write, mem_to_reg, ir_write, reg_dst, reg_write, alu_src_a;
    logic [1:0]  alu_src_b, pc_source, alu_op;
    logic        pc_sel, illegal, halted;
    logic [15:0] retire_cnt;
    logic [3:0]  state_o;
    logic [16:0] ctl;

    logic        w_reset = 1'b1;
    logic [3:0]  w_op = 4'b0000;
    logic        w_zero = 1'b0;
    logic        w_mem_ready = 1'b0;
    logic        w_resume = 1'b0;
    logic        w_iord, w_mem_read, w_mem_write, w_mem_to_reg, w_ir_write, w_reg_dst;
    logic        w_reg_write, w_alu_src_a;
    logic [1:0]  w_alu_src_b, w_pc_source, w_alu_op;
    logic        w_pc_sel, w_illegal, w_halted;
    logic [3:0]  w_retire_cnt;
    logic [3:0]  w_state;

    int unsigned n_pass = 0;
    int unsigned n_total = 0;

    mc_ctrl_fsm u_dut (
        .clk        (clk),
        .reset      (reset),
        .op         (op),
        .zero       (zero),
        .mem_ready  (mem_ready),
        .resume     (resume),
        .iord       (iord),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .mem_to_reg (mem_to_reg),
        .ir_write   (ir_write),
        .reg_dst    (reg_dst),
        .reg_write  (reg_write),
        .alu_src_a  (alu_src_a),
        .alu_src_b  (alu_src_b),
        .pc_source  (pc_source),
        .alu_op     (alu_op),
        .pc_sel     (pc_sel),
        .illegal    (illegal),
        .halted     (halted),
        .retire_cnt (retire_cnt),
        .state_o    (state_o)
    );

    mc_ctrl_fsm #(
        .OP_W    (4),
        .WAIT_EN (0),
        .RET_W   (4)
    ) u_dut_w (
        .clk        (clk),
        .reset      (w_reset),
        .op         (w_op),
        .zero       (w_zero),
        .mem_ready  (w_mem_ready),
        .resume     (w_resume),
        .iord       (w_iord),
        .mem_read   (w_mem_read),
        .mem_write  (w_mem_write),
        .mem_to_reg (w_mem_to_reg),
        .ir_write   (w_ir_write),
        .reg_dst    (w_reg_dst),
        .reg_write  (w_reg_write),
        .alu_src_a  (w_alu_src_a),
        .alu_src_b  (w_alu_src_b),
        .pc_source  (w_pc_source),
        .alu_op     (w_alu_op),
        .pc_sel     (w_pc_sel),
        .illegal    (w_illegal),
        .halted     (w_halted),
        .retire_cnt (w_retire_cnt),
        .state_o    (w_state)
    );

    // Control bundle: iord,mrd,mwr,m2r,irw,rdst,rwr,asa,asb[2],pcs[2],aop[2],pc_sel,ill,halt
    assign ctl = {iord, mem_read, mem_write, mem_to_reg, ir_write, reg_dst, reg_write, alu_src_a,
                  alu_src_b, pc_source, alu_op, pc_sel, illegal, halted};

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        op = 4'b1010;
        mem_ready = 1'b1;
        zero = 1'b0;
        resume = 1'b0;
        do_reset();
        n_total++;
        if (state_o !== 4'd0) $display("FAIL reset_state: got %0d want 0", state_o);
        else n_pass++;
        n_total++;
        if (retire_cnt !== 16'd0) $display("FAIL reset_retire: got %0d want 0", retire_cnt);
        else n_pass++;
        n_total++;
        if (ctl !== 17'b0_1_0_0_1_0_0_0_01_00_00_1_0_0)
            $display("FAIL reset_ctl: got %b want %b", ctl, 17'b0_1_0_0_1_0_0_0_01_00_00_1_0_0);
        else n_pass++;
    endtask

    task automatic test_load();
        logic [3:0] exp_st [0:10];
        logic       rdy    [0:10];
        int         rw_pulses;
        exp_st = '{4'd0, 4'd0, 4'd0, 4'd1, 4'd2, 4'd3, 4'd3, 4'd3, 4'd3, 4'd4, 4'd0};
        rdy    = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        rw_pulses = 0;
        op = 4'b1010;
        do_reset();
        for (int i = 0; i < 11; i++) begin
            mem_ready = rdy[i];
            #1;
            n_total++;
            if (state_o !== exp_st[i])
                $display("FAIL load_state[%0d]: got %0d want %0d", i, state_o, exp_st[i]);
            else n_pass++;
            if (i < 2) begin
                n_total++;
                if (ctl !== 17'b0_1_0_0_0_0_0_0_01_00_00_0_0_0)
                    $display("FAIL load_fetch_wait_ctl[%0d]: got %b", i, ctl);
                else n_pass++;
            end
            if (i >= 5 && i <= 8) begin
                n_total++;
                if (ctl !== 17'b1_1_0_0_0_0_0_0_00_00_00_0_0_0)
                    $display("FAIL load_memrd_ctl[%0d]: got %b", i, ctl);
                else n_pass++;
            end
            if (reg_write === 1'b1) rw_pulses++;
            if (i < 10) step();
        end
        n_total++;
        if (rw_pulses != 1) $display("FAIL load_reg_write_pulses: got %0d want 1", rw_pulses);
        else n_pass++;
        n_total++;
        if (retire_cnt !== 16'd1) $display("FAIL load_retire: got %0d want 1", retire_cnt);
        else n_pass++;
        mem_ready = 1'b1;
    endtask

    task automatic test_beq();
        logic [16:0] exp_ctl;
        op = 4'b1011;
        mem_ready = 1'b1;
        do_reset();
        for (int k = 0; k < 2; k++) begin
            zero = (k == 0);
            step();
            step();
            exp_ctl = {8'b0000_0001, 2'b00, 2'b01, 2'b01, (k == 0), 2'b00};
            n_total++;
            if (state_o !== 4'd8) $display("FAIL beq_state[%0d]: got %0d want 8", k, state_o);
            else n_pass++;
            n_total++;
            if (ctl !== exp_ctl) $display("FAIL beq_ctl[%0d]: got %b want %b", k, ctl, exp_ctl);
            else n_pass++;
            step();
            n_total++;
            if (retire_cnt !== 16'(k + 1))
                $display("FAIL beq_retire[%0d]: got %0d want %0d", k, retire_cnt, k + 1);
            else n_pass++;
        end
        zero = 1'b0;
    endtask

    task automatic test_illegal();
        op = 4'b0111;
        mem_ready = 1'b1;
        do_reset();
        step();
        n_total++;
        if (illegal !== 1'b0) $display("FAIL ill_decode: got %b want 0", illegal);
        else n_pass++;
        step();
        n_total++;
        if (state_o !== 4'd13) $display("FAIL ill_state: got %0d want 13", state_o);
        else n_pass++;
        n_total++;
        if (ctl !== 17'd2) $display("FAIL ill_ctl: got %b want %b", ctl, 17'd2);
        else n_pass++;
        step();
        n_total++;
        if ({illegal, state_o} !== 5'b0_0000)
            $display("FAIL ill_return: got ill=%b st=%0d want ill=0 st=0", illegal, state_o);
        else n_pass++;
        n_total++;
        if (retire_cnt !== 16'd0) $display("FAIL ill_retire: got %0d want 0", retire_cnt);
        else n_pass++;
    endtask

    task automatic test_halt();
        op = 4'b1111;
        mem_ready = 1'b1;
        resume = 1'b0;
        do_reset();
        step();
        step();
        n_total++;
        if (retire_cnt !== 16'd1) $display("FAIL halt_retire: got %0d want 1", retire_cnt);
        else n_pass++;
        for (int i = 0; i < 10; i++) begin
            n_total++;
            if ({halted, state_o} !== 5'b1_1100 || ctl !== 17'd1)
                $display("FAIL halt_hold[%0d]: got halted=%b st=%0d ctl=%b want 1,12", i, halted,
                         state_o, ctl);
            else n_pass++;
            step();
        end
        resume = 1'b1;
        step();
        resume = 1'b0;
        n_total++;
        if ({halted, state_o} !== 5'b0_0000)
            $display("FAIL halt_resume: got halted=%b st=%0d want 0,0", halted, state_o);
        else n_pass++;
    endtask

    task automatic test_reset_midwait();
        op = 4'b0000;
        mem_ready = 1'b1;
        do_reset();
        repeat (4) step();
        n_total++;
        if (retire_cnt !== 16'd1) $display("FAIL midwait_pre_retire: got %0d want 1", retire_cnt);
        else n_pass++;
        op = 4'b1001;
        step();
        step();
        mem_ready = 1'b0;
        step();
        n_total++;
        if ({state_o, mem_write} !== 5'b0101_1)
            $display("FAIL midwait_memwr: got st=%0d mw=%b want 5,1", state_o, mem_write);
        else n_pass++;
        step();
        n_total++;
        if (state_o !== 4'd5) $display("FAIL midwait_hold: got %0d want 5", state_o);
        else n_pass++;
        do_reset();
        n_total++;
        if (state_o !== 4'd0) $display("FAIL midwait_reset_state: got %0d want 0", state_o);
        else n_pass++;
        n_total++;
        if (ctl !== 17'b0_1_0_0_0_0_0_0_01_00_00_0_0_0)
            $display("FAIL midwait_reset_ctl: got %b", ctl);
        else n_pass++;
        n_total++;
        if (retire_cnt !== 16'd0) $display("FAIL midwait_retire: got %0d want 0", retire_cnt);
        else n_pass++;
        mem_ready = 1'b1;
    endtask

    task automatic test_wrap_nowait();
        logic [3:0] exp_st [0:3];
        exp_st = '{4'd0, 4'd1, 4'd6, 4'd7};
        w_op = 4'b0000;
        w_mem_ready = 1'b0;
        w_reset = 1'b1;
        step();
        w_reset = 1'b0;
        n_total++;
        if (w_ir_write !== 1'b1) $display("FAIL nowait_ir_write: got %b want 1", w_ir_write);
        else n_pass++;
        for (int n = 0; n < 16; n++) begin
            n_total++;
            if (w_retire_cnt !== 4'(n))
                $display("FAIL wrap_retire[%0d]: got %0d want %0d", n, w_retire_cnt, n);
            else n_pass++;
            for (int c = 0; c < 4; c++) begin
                n_total++;
                if (w_state !== exp_st[c])
                    $display("FAIL nowait_state[%0d.%0d]: got %0d want %0d", n, c, w_state,
                             exp_st[c]);
                else n_pass++;
                step();
            end
        end
        n_total++;
        if (w_retire_cnt !== 4'd0) $display("FAIL wrap_zero: got %0d want 0", w_retire_cnt);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_load();
        test_beq();
        test_illegal();
        test_halt();
        test_reset_midwait();
        test_wrap_nowait();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
